double_shift_left_seq: RTL and testbench
========================================

Name: double_shift_left_seq

Overview:
- Multi-cycle 64-bit double shift left unit: the left-direction counterpart of the double shift right datapath in the VCPU-32 shift/merge path.
- Concatenates operands a (upper word) and b (lower word), shifts the 64-bit value left by sa, and returns the upper word.
- Implemented as a log-step sequential shifter: one shift stage (16, 8, 4, 2, 1) per clock, with a start/busy/done handshake toward the execute-stage sequencer.
- Trades latency for area versus a full combinational funnel shifter.

Parameters:
- WIDTH, 32, word width of a, b, y; the internal shift register is 2*WIDTH bits.
- SA_W, 5, shift amount width; must equal log2(WIDTH); one SHIFT cycle per sa bit.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  upper operand word, bit 0 = MSB.
- b  input  WIDTH  lower operand word, bit 0 = MSB.
- sa  input  SA_W  shift amount, 0..WIDTH-1, unsigned.
- y  output  WIDTH  result = upper WIDTH bits of ({a,b} << sa).
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle result-valid pulse.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high, so it is sampled only on the rising edge of clk and has no asynchronous path.
- Function: y = (a << sa) | (b >> (WIDTH-sa)) for sa != 0; for sa = 0, y = a. Bits shifted out of the top are discarded; zeros fill the bottom. No sign handling.
- Reset (rst=1 at an edge): state=IDLE, y=0, busy=0, done=0, internal 64-bit register=0, step counter=0. Reset takes priority over every other condition, including mid-operation; the operation in flight is dropped and no done pulse is generated.
- States: IDLE, SHIFT, DONE.
- IDLE: on an edge with start=1, latch {a,b} into the shift register, latch sa, set the step counter to SA_W-1, and go to SHIFT. busy rises after that edge. With start=0, remain in IDLE.
- SHIFT: each edge consumes one latched sa bit, from MSB to LSB. When sa bit k is set, the register shifts left by 2^k; otherwise it holds. Decrement the counter. When the edge processes the bit with k=0, load y with register bits [0:WIDTH-1] after the shift and go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle. The next edge returns to IDLE with done=0 and busy=0.
- Latency: start sampled at edge E0, SHIFT edges E1..E5, y and done valid in the cycle after E5, idle after E6. The same start edge cannot be re-sampled until E6, so the earliest back-to-back start is at edge E6 (6-cycle throughput).
- start while busy: ignored. Operands are not re-latched and no queueing is performed.
- Inputs a, b, and sa may change freely after E0 without affecting the result.
- y holds its last result through IDLE until the next DONE; it is not cleared by a new start.
- sa = 0: five SHIFT cycles still execute (fixed latency); y = a.
- sa = WIDTH-1 is the maximum; the SA_W-bit width makes out-of-range values impossible.

Test Plan:
- Reset, then a=0x0000FF0F, b=0x00000FFF, sa=5, pulse start -> done exactly 6 cycles after the start edge, y=0x001FE1E0, busy high for 6 cycles.
- a=0x12345678, b=0x9ABCDEF0, sa=4 -> y=0x23456789. Then sa=0 with the same operands -> y=0x12345678 after the same 6-cycle latency.
- a=0x00000001, b=0x80000000, sa=31 -> y=0xC0000000. a=0xFFFFFFFF, b=0x00000000, sa=16 -> y=0xFFFF0000.
- Hold start=1 continuously with the operands changed at cycle 2 -> the first result uses the E0 operands, the second start is sampled at E6, and done pulses are exactly 6 cycles apart.
- Assert rst at cycle 3 of an operation -> next cycle busy=0, done=0, y=0, and no done pulse follows. A new start then completes normally.
- Random a, b, sa (≥1000 vectors) versus the reference model ({a,b}<<sa)[63:32] -> all match, and done is high for exactly one cycle per start.

Source files
------------

// File: rtl/double_shift_left_seq.sv
`default_nettype none
// ============================================================================
//  Module      : double_shift_left_seq
//  Description : Multi-cycle 64-bit double shift left.
//                y = upper WIDTH bits of ({a,b} << sa).
//                The shift runs as a log-step sequence, one stage per
//                clock (16, 8, 4, 2, 1), with a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
//
//  Bit numbering note: the VCPU-32 documentation numbers bit 0 as the MSB.
//  This RTL uses conventional [WIDTH-1:0] vectors, so architectural bit 0
//  is vector bit WIDTH-1 here. The register slice the architecture calls
//  [0:WIDTH-1] is therefore r_shreg[2*WIDTH-1:WIDTH].
//
//  Timing (start sampled at edge E0):
//    E1..E5  one shift stage per edge, MSB of sa first
//    E5      y loaded, done/busy high during the following cycle
//    E6      back to IDLE, or straight into a new operation if start is
//            high at E6, which gives a sustained 6-cycle throughput
// ============================================================================

module double_shift_left_seq #(
    parameter int WIDTH = 32,
    parameter int SA_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SA_W-1:0]  sa,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int DW    = 2 * WIDTH;
    localparam int CNT_W = (SA_W > 1) ? $clog2(SA_W) : 1;

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(SA_W - 1);
    localparam logic [CNT_W-1:0] c_cnt_last = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [DW-1:0]    r_shreg;   // {a,b} being shifted
    logic [SA_W-1:0]  r_sa;      // latched shift amount
    logic [CNT_W-1:0] r_cnt;     // index of the sa bit processed next
    logic [WIDTH-1:0] r_y;
    logic             r_busy;
    logic             r_done;

    // ------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------
    logic [DW-1:0]    w_stage [SA_W];   // candidate result of each stage
    logic [DW-1:0]    w_next;           // register value after this edge
    logic             w_accept;         // start is taken on this edge
    logic             w_last;           // this edge processes sa bit 0

    // Each stage k either shifts by 2^k or holds, depending on sa bit k.
    // Only the stage selected by the counter is used on a given edge.
    generate
        for (genvar k = 0; k < SA_W; k++) begin : g_stage
            assign w_stage[k] = r_sa[k] ? (r_shreg << (1 << k)) : r_shreg;
        end
    endgenerate

    // Select the stage addressed by the step counter.
    always_comb begin
        w_next = r_shreg;
        for (int k = 0; k < SA_W; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_next = w_stage[k];
            end
        end
    end

    // A new request is accepted from IDLE, or from DONE so that a held
    // start chains directly into the next operation at the 6-cycle mark.
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_cnt == c_cnt_last);

    // Sequencer: operand capture, one shift stage per clock, result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_sa    <= '0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg <= {a, b};
                        r_sa    <= sa;
                        r_cnt   <= c_cnt_init;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    r_shreg <= w_next;
                    r_cnt   <= r_cnt - c_cnt_one;
                    if (w_last) begin
                        r_y     <= w_next[DW-1:WIDTH];
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (w_accept) begin
                        r_shreg <= {a, b};
                        r_sa    <= sa;
                        r_cnt   <= c_cnt_init;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign y    = r_y;
    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_double_shift_left_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_double_shift_left_seq
//  Description : Directed and random self-checking bench for
//                double_shift_left_seq.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_double_shift_left_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [31:0] y;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    double_shift_left_seq #(
        .WIDTH (32),
        .SA_W  (5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sa    (sa),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_dsl(input logic [31:0] ra, input logic [31:0] rb,
                                            input logic [4:0] rs);
        logic [63:0] cat;
        cat = {ra, rb} << rs;
        return cat[63:32];
    endfunction

    // One complete operation: start at E0, scramble inputs afterwards,
    // then check latency, result, busy span and the single done pulse.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv,
                         input logic [4:0] ts, input logic [31:0] ex, input string tag);
        int          cyc;
        int          bcnt;
        logic [31:0] yold;
        @(negedge clk);
        a     = ta;
        b     = tbv;
        sa    = ts;
        start = 1'b1;
        yold  = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sa    = 5'($urandom);
        chk({tag, "_yhold"}, y, yold);
        cyc  = 1;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 12) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
        if (busy === 1'b1) bcnt++;
        chk({tag, "_lat"}, cyc, 6);
        chk({tag, "_y"}, y, ex);
        chk({tag, "_busy"}, bcnt, 6);
        @(negedge clk);
        chk({tag, "_done1"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int          cyc;
        int          nd;
        int          d1;
        int          d2;
        logic [31:0] y1;
        logic [31:0] y2;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rs;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sa    = '0;
        repeat (3) @(negedge clk);
        chk("reset", {y, busy, done}, 34'd0);
        rst = 1'b0;

        // Directed vectors
        do_op(32'h0000FF0F, 32'h00000FFF, 5'd5,  32'h001FE1E0, "v_sa5");
        do_op(32'h12345678, 32'h9ABCDEF0, 5'd4,  32'h23456789, "v_sa4");
        do_op(32'h12345678, 32'h9ABCDEF0, 5'd0,  32'h12345678, "v_sa0");
        do_op(32'h00000001, 32'h80000000, 5'd31, 32'hC0000000, "v_sa31");
        do_op(32'hFFFFFFFF, 32'h00000000, 5'd16, 32'hFFFF0000, "v_sa16");

        // y holds through idle cycles
        repeat (4) @(negedge clk);
        chk("idle_hold", y, 32'hFFFF0000);

        // start held high: second start sampled at E6, done pulses 6 apart
        @(negedge clk);
        a     = 32'h12345678;
        b     = 32'h9ABCDEF0;
        sa    = 5'd4;
        start = 1'b1;
        nd = 0; d1 = 0; d2 = 0; y1 = '0; y2 = '0;
        for (cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                a  = 32'hFFFFFFFF;
                b  = 32'h00000000;
                sa = 5'd16;
            end
            if (cyc == 8) start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                if (nd == 1) begin d1 = cyc; y1 = y; end
                if (nd == 2) begin d2 = cyc; y2 = y; end
            end
        end
        chk("b2b_d1", d1, 6);
        chk("b2b_y1", y1, 32'h23456789);
        chk("b2b_d2", d2, 12);
        chk("b2b_y2", y2, 32'hFFFF0000);
        chk("b2b_cnt", nd, 2);

        // Reset mid-operation drops the operation
        @(negedge clk);
        a     = 32'h0000FF0F;
        b     = 32'h00000FFF;
        sa    = 5'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid", {y, busy, done}, 34'd0);
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        chk("rst_nodone", nd, 0);
        do_op(32'h00000001, 32'h80000000, 5'd31, 32'hC0000000, "v_post_rst");

        // Random vectors against the reference model
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 5'($urandom);
            do_op(ra, rb, rs, ref_dsl(ra, rb, rs), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
